spi_master_cfg: RTL and testbench
=================================

# spi_master_cfg

Parametrised SPI master, the next generation of the fixed 26-bit SPI master core. Adds configurable word width, an SCLK divider, per-transfer SPI mode (CPOL/CPHA) and multiple active-low chip selects. Response backpressure holds the completed word until the consumer accepts it. Sits between a request/response method pair (atomicc ENA/RDY convention) and the SPI pins.

## Interface

Parameters:
- WIDTH, 26, bits per transfer; MSB shifted first; WIDTH >= 1.
- DIV, 4, CLK cycles per SCLK half-period; DIV >= 1.
- NUM_CS, 1, number of chip-select outputs; CSW = max(1, clog2(NUM_CS)).

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- nRST  in  1  reset, synchronous and active-high (1 = reset); one clock, synchronous active-high reset.
- request_enq__ENA  in  1  request strobe; only legal while request_enq__RDY=1.
- request_enq__RDY  out  1  block idle, request accepted this cycle if ENA.
- request_enq_data  in  WIDTH  word to transmit.
- request_enq_cs  in  CSW  chip-select index.
- request_enq_cpol  in  1  SCLK idle level for this transfer.
- request_enq_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- response_enq__ENA  out  1  received word valid.
- response_enq__RDY  in  1  consumer accepts; transfer completes on ENA&&RDY.
- response_enq_data  out  WIDTH  received word.
- spi_sclk  out  1  SPI clock.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in; sampled synchronously, no synchroniser inside.
- spi_cs_n  out  NUM_CS  active-low chip selects.

## Operation

- States: IDLE, SETUP, SHIFT, HOLD, RESP.
- IDLE: request_enq__RDY=1. On ENA, the block latches data, cs, cpol and cpha, and moves to SETUP.
- SETUP (DIV cycles): spi_cs_n[cs]=0 and sclk=cpol. When cpha=0, mosi = data[WIDTH-1].
- SHIFT: 2*WIDTH half-periods of DIV cycles. sclk toggles at the end of each half-period.
  - Odd edges (1,3,..) are leading, even edges are trailing.
  - cpha=0: sample miso on leading edges; shift mosi on trailing edges, except the final edge.
  - cpha=1: shift mosi on leading edges (the first leading edge presents the MSB); sample on trailing edges.
  - Received bits shift in at the LSB; after WIDTH samples, rx[WIDTH-1] holds the first bit sampled.
- HOLD (DIV cycles): sclk=cpol and CS still asserted.
- RESP: all CS deasserted. response_enq__ENA=1 with data = rx, held stable until response_enq__RDY. On ENA&&RDY the block returns to IDLE.
- request_enq__RDY=0 in every state except IDLE. At most one transfer is in flight.
- cs index >= NUM_CS: the transfer runs fully with no CS asserted, and a response is still produced.
- Mode changes take effect only at request acceptance. In IDLE, sclk sits at the cpol of the last transfer (0 after reset).
- Counters: the half-period counter is clog2(DIV+1) bits and wraps to 0 on reaching DIV-1. The edge counter is clog2(2*WIDTH+1) bits. There is no arithmetic overflow of any datapath.

## Timing

- Reset values (cycle after nRST=1 sampled): state IDLE, spi_cs_n all 1, spi_sclk 0, spi_mosi 0, response_enq__ENA 0, response_enq_data 0, request_enq__RDY 0 while nRST=1 and 1 on the first cycle after release.
- Reset mid-transfer: abort. Next cycle CS is all 1, sclk 0, no response is issued, and the latched data is discarded.
- Request accepted at cycle T:
  - CS asserts at T+1.
  - Edge k (1..2*WIDTH) is visible at T+1+k*DIV.
  - response_enq__ENA rises and CS deasserts at T+1+(2*WIDTH+1)*DIV.
- With immediate RDY, the next request is acceptable one cycle after the response handshake.
- Throughput is one word per (2*WIDTH+1)*DIV+2 cycles, minimum.
- ENA&&RDY on request and response in the same cycle cannot occur, because the states are exclusive.

## Test plan

- Reset: hold nRST=1 for 3 cycles mid-transfer (WIDTH=8, DIV=2) -> next cycle spi_cs_n=all 1, sclk=0, no response_enq__ENA, RDY=1 after release.
- Mode 0 loopback (miso=mosi), WIDTH=8, DIV=2, data=0xA5, cs=0 -> 16 sclk edges, first rising at T+3, response 0xA5 at T+35, cs_n[0] low T+1..T+34.
- All four modes with a slave model driving 0x3C, data=0xC3 -> the slave captures 0xC3 and the response is 0x3C in each mode. sclk idle equals cpol before and after.
- Backpressure: hold response_enq__RDY=0 for 10 cycles -> ENA and data stay stable, request_enq__RDY=0, CS deasserted. Accept -> IDLE the next cycle.
- NUM_CS=4: cs=2 selects only spi_cs_n[2]. cs=3 then cs=1 back-to-back -> correct single line low each time, never two low.
- DIV=1, WIDTH=1 boundary: data=1, miso=0 -> exactly 2 edges, response 0 at T+4. Also WIDTH=26 (default) completes at T+1+53*DIV.

Source files
------------

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master: WIDTH-bit MSB-first transfers, per-request CPOL/CPHA, NUM_CS active-low selects.
// Latency: CS at T+1, edge k at T+1+k*DIV, response at T+1+(2*WIDTH+1)*DIV after acceptance at T.
// Backpressure: the response word is held with ENA high until RDY; no new request is taken meanwhile.
module spi_master_cfg #(
  parameter int WIDTH  = 26,
  parameter int DIV    = 4,
  parameter int NUM_CS = 1,
  localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              request_enq__ENA,
  output logic              request_enq__RDY,
  input  logic [WIDTH-1:0]  request_enq_data,
  input  logic [CSW-1:0]    request_enq_cs,
  input  logic              request_enq_cpol,
  input  logic              request_enq_cpha,
  output logic              response_enq__ENA,
  input  logic              response_enq__RDY,
  output logic [WIDTH-1:0]  response_enq_data,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int DCW = $clog2(DIV + 1);
  localparam int ECW = $clog2(2 * WIDTH + 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [ECW-1:0] EDGE_LAST = ECW'(2 * WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [DCW-1:0]     div_q, div_d;
  logic [ECW-1:0]     edge_q, edge_d;
  logic [WIDTH-1:0]   tx_q, tx_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic               mosi_q, mosi_d;
  logic               sclk_q, sclk_d;
  logic               cpha_q, cpha_d;
  logic [NUM_CS-1:0]  cs_n_q, cs_n_d;

  logic half_done;
  logic sample_edge;
  logic last_edge;

  // Next-state logic: sequencing, SCLK generation, MOSI shift and MISO capture.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    cpha_d  = cpha_q;
    cs_n_d  = cs_n_q;

    half_done = (div_q == DIV_LAST);
    // edge_q counts edges already made, so the edge about to happen is leading when edge_q is even.
    sample_edge = (~edge_q[0]) ^ cpha_q;
    last_edge   = (edge_q == EDGE_LAST);

    case (state_q)
      S_IDLE: begin
        if (request_enq__ENA && request_enq__RDY) begin
          state_d = S_SETUP;
          div_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          sclk_d  = request_enq_cpol;
          cpha_d  = request_enq_cpha;
          if (!request_enq_cpha) begin
            // MSB must be on the wire before the first (sampling) leading edge.
            mosi_d = request_enq_data[WIDTH-1];
            tx_d   = request_enq_data << 1;
          end else begin
            mosi_d = 1'b0;
            tx_d   = request_enq_data;
          end
          // An out-of-range index matches no line, so the transfer runs unselected.
          for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = (request_enq_cs != CSW'(i));
          end
        end
      end
      S_SETUP, S_SHIFT: begin
        div_d = half_done ? '0 : div_q + DCW'(1);
        if (half_done) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + ECW'(1);
          if (sample_edge) begin
            rx_d = (rx_q << 1) | WIDTH'(spi_miso);
          end else if (!last_edge) begin
            mosi_d = tx_q[WIDTH-1];
            tx_d   = tx_q << 1;
          end
          state_d = last_edge ? S_HOLD : S_SHIFT;
        end
      end
      S_HOLD: begin
        div_d = half_done ? '0 : div_q + DCW'(1);
        if (half_done) begin
          state_d = S_RESP;
          cs_n_d  = '1;
        end
      end
      S_RESP: begin
        if (response_enq__RDY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = '1;
      end
    endcase
  end

  // State registers with synchronous active-high reset; reset aborts any transfer in flight.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cpha_q  <= 1'b0;
      cs_n_q  <= '1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cpha_q  <= cpha_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign request_enq__RDY  = (state_q == S_IDLE) && !nRST;
  assign response_enq__ENA = (state_q == S_RESP);
  assign response_enq_data = rx_q;
  assign spi_sclk          = sclk_q;
  assign spi_mosi          = mosi_q;
  assign spi_cs_n          = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: three instances (8-bit/DIV2/4 CS, 1-bit/DIV1, 26-bit/DIV4).
// Outputs are observed on the falling CLK edge; "n" is the cycle index after acceptance (n=1 is T+1).
// A small SPI slave model on the 8-bit instance checks all four modes.
module tb_spi_master_cfg;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic nRST;
  int checks = 0;
  int failures = 0;

  // 8-bit instance
  logic       ena8, rdy8, cpol8, cpha8, rsp_ena8, rsp_rdy8, sclk8, mosi8, miso8, lb8, slv_miso;
  logic [7:0] data8, rsp_data8;
  logic [1:0] cs8;
  logic [3:0] csn8;
  assign miso8 = lb8 ? mosi8 : slv_miso;

  spi_master_cfg #(.WIDTH(8), .DIV(2), .NUM_CS(4)) dut8 (
    .CLK(CLK), .nRST(nRST),
    .request_enq__ENA(ena8), .request_enq__RDY(rdy8), .request_enq_data(data8),
    .request_enq_cs(cs8), .request_enq_cpol(cpol8), .request_enq_cpha(cpha8),
    .response_enq__ENA(rsp_ena8), .response_enq__RDY(rsp_rdy8), .response_enq_data(rsp_data8),
    .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_miso(miso8), .spi_cs_n(csn8)
  );

  // 1-bit, DIV=1 instance
  logic       ena1, rdy1, cpol1, cpha1, rsp_ena1, rsp_rdy1, sclk1, mosi1, miso1;
  logic [0:0] data1, rsp_data1, cs1, csn1;

  spi_master_cfg #(.WIDTH(1), .DIV(1), .NUM_CS(1)) dut1 (
    .CLK(CLK), .nRST(nRST),
    .request_enq__ENA(ena1), .request_enq__RDY(rdy1), .request_enq_data(data1),
    .request_enq_cs(cs1), .request_enq_cpol(cpol1), .request_enq_cpha(cpha1),
    .response_enq__ENA(rsp_ena1), .response_enq__RDY(rsp_rdy1), .response_enq_data(rsp_data1),
    .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_cs_n(csn1)
  );

  // 26-bit default-geometry instance, MISO looped back from MOSI
  logic        ena26, rdy26, cpol26, cpha26, rsp_ena26, rsp_rdy26, sclk26, mosi26, miso26;
  logic [25:0] data26, rsp_data26;
  logic [0:0]  cs26, csn26;
  assign miso26 = mosi26;

  spi_master_cfg #(.WIDTH(26), .DIV(4), .NUM_CS(1)) dut26 (
    .CLK(CLK), .nRST(nRST),
    .request_enq__ENA(ena26), .request_enq__RDY(rdy26), .request_enq_data(data26),
    .request_enq_cs(cs26), .request_enq_cpol(cpol26), .request_enq_cpha(cpha26),
    .response_enq__ENA(rsp_ena26), .response_enq__RDY(rsp_rdy26), .response_enq_data(rsp_data26),
    .spi_sclk(sclk26), .spi_mosi(mosi26), .spi_miso(miso26), .spi_cs_n(csn26)
  );

  // SPI slave model on spi_cs_n[0] of the 8-bit instance, evaluated half a CLK after each edge.
  logic [7:0] slv_word, slv_sh, slv_rx;
  logic       slv_cpha;
  logic       cs_prev = 1'b1;
  logic       sclk_prev = 1'b0;
  int         slv_edges;
  always @(negedge CLK) begin
    if (!csn8[0] && cs_prev) begin
      slv_edges = 0;
      slv_rx    = 8'h00;
      slv_sh    = slv_word;
      if (!slv_cpha) begin
        slv_miso = slv_sh[7];
        slv_sh   = slv_sh << 1;
      end
    end else if (!csn8[0] && !cs_prev && sclk8 !== sclk_prev) begin
      slv_edges++;
      if (slv_edges[0] ^ slv_cpha) begin
        slv_rx = {slv_rx[6:0], mosi8};
      end else begin
        slv_miso = slv_sh[7];
        slv_sh   = slv_sh << 1;
      end
    end
    cs_prev   = csn8[0];
    sclk_prev = sclk8;
  end

  // Present one request to the 8-bit instance; called on a falling edge, returns at n=1.
  task automatic issue8(input logic [7:0] d, input logic [1:0] c, input logic pol, input logic pha);
    data8 = d; cs8 = c; cpol8 = pol; cpha8 = pha; ena8 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ena8 = 1'b0;
  endtask

  // Advance until the 8-bit response appears (bounded); returns its cycle index and whether
  // any chip-select pattern other than 'allowed' or all-high was seen.
  task automatic wait_rsp8(input logic [3:0] allowed, output int n, output bit cs_bad);
    n = 1;
    cs_bad = 1'b0;
    while (rsp_ena8 !== 1'b1 && n < 80) begin
      if (csn8 !== allowed && csn8 !== 4'hF) cs_bad = 1'b1;
      @(negedge CLK);
      n++;
    end
    if (csn8 !== 4'hF) cs_bad = 1'b1;
  endtask

  task automatic test_reset;
    nRST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (rdy8 !== 1'b0) begin failures++; $display("FAIL reset_rdy_held: got %b want 0", rdy8); end
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (csn8 !== 4'hF) begin failures++; $display("FAIL reset_csn: got %h want f", csn8); end
    checks++; if (sclk8 !== 1'b0 || mosi8 !== 1'b0) begin failures++; $display("FAIL reset_pins: sclk %b mosi %b want 0 0", sclk8, mosi8); end
    checks++; if (rsp_ena8 !== 1'b0 || rsp_data8 !== 8'h00) begin failures++; $display("FAIL reset_rsp: ena %b data %h want 0 00", rsp_ena8, rsp_data8); end
    checks++; if (rdy8 !== 1'b1 || rdy1 !== 1'b1 || rdy26 !== 1'b1) begin failures++; $display("FAIL reset_rdy_release: got %b%b%b want 111", rdy8, rdy1, rdy26); end
    // Abort a mode-3 transfer while SCLK is high.
    lb8 = 1'b1;
    issue8(8'hFF, 2'd0, 1'b1, 1'b1);
    repeat (9) @(negedge CLK);
    checks++; if (sclk8 !== 1'b1 || csn8 !== 4'hE) begin failures++; $display("FAIL abort_pre: sclk %b csn %h want 1 e", sclk8, csn8); end
    nRST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (csn8 !== 4'hF || sclk8 !== 1'b0 || rsp_ena8 !== 1'b0) begin failures++; $display("FAIL abort_next: csn %h sclk %b ena %b want f 0 0", csn8, sclk8, rsp_ena8); end
    repeat (2) @(posedge CLK);
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++; if (rdy8 !== 1'b1) begin failures++; $display("FAIL abort_rdy: got %b want 1", rdy8); end
    begin
      bit seen;
      seen = 1'b0;
      repeat (40) begin
        if (rsp_ena8 !== 1'b0 || csn8 !== 4'hF) seen = 1'b1;
        @(negedge CLK);
      end
      checks++; if (seen) begin failures++; $display("FAIL abort_quiet: response or CS after abort seen=%b want 0", seen); end
    end
  endtask

  task automatic test_mode0_loopback;
    lb8 = 1'b1;
    issue8(8'hA5, 2'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 35; n++) begin
      int e;
      e = (n - 1) / 2;
      if (e > 16) e = 16;
      checks++; if (sclk8 !== e[0]) begin failures++; $display("FAIL m0_sclk n=%0d: got %b want %b", n, sclk8, e[0]); end
      checks++; if (csn8 !== ((n <= 34) ? 4'hE : 4'hF)) begin failures++; $display("FAIL m0_csn n=%0d: got %h", n, csn8); end
      checks++; if (rsp_ena8 !== (n == 35)) begin failures++; $display("FAIL m0_ena n=%0d: got %b", n, rsp_ena8); end
      if (n < 35) @(negedge CLK);
    end
    checks++; if (rsp_data8 !== 8'hA5) begin failures++; $display("FAIL m0_data: got %h want a5", rsp_data8); end
    @(negedge CLK);
    checks++; if (rdy8 !== 1'b1 || rsp_ena8 !== 1'b0) begin failures++; $display("FAIL m0_idle: rdy %b ena %b want 1 0", rdy8, rsp_ena8); end
  endtask

  task automatic test_modes;
    lb8 = 1'b0;
    slv_word = 8'h3C;
    for (int m = 0; m < 4; m++) begin
      int n;
      bit bad;
      slv_cpha = m[0];
      issue8(8'hC3, 2'd0, m[1], m[0]);
      checks++; if (sclk8 !== m[1]) begin failures++; $display("FAIL mode%0d_setup_sclk: got %b want %b", m, sclk8, m[1]); end
      wait_rsp8(4'hE, n, bad);
      checks++; if (n !== 35) begin failures++; $display("FAIL mode%0d_latency: got n=%0d want 35", m, n); end
      checks++; if (rsp_data8 !== 8'h3C) begin failures++; $display("FAIL mode%0d_rsp: got %h want 3c", m, rsp_data8); end
      checks++; if (slv_rx !== 8'hC3) begin failures++; $display("FAIL mode%0d_slave_rx: got %h want c3", m, slv_rx); end
      checks++; if (sclk8 !== m[1]) begin failures++; $display("FAIL mode%0d_end_sclk: got %b want %b", m, sclk8, m[1]); end
      @(negedge CLK);
    end
  endtask

  task automatic test_backpressure;
    int n;
    bit bad;
    lb8 = 1'b1;
    rsp_rdy8 = 1'b0;
    issue8(8'h5A, 2'd0, 1'b0, 1'b0);
    wait_rsp8(4'hE, n, bad);
    checks++; if (n !== 35) begin failures++; $display("FAIL bp_latency: got n=%0d want 35", n); end
    repeat (10) begin
      checks++;
      if (rsp_ena8 !== 1'b1 || rsp_data8 !== 8'h5A || rdy8 !== 1'b0 || csn8 !== 4'hF) begin
        failures++;
        $display("FAIL bp_hold: ena %b data %h rdy %b csn %h want 1 5a 0 f", rsp_ena8, rsp_data8, rdy8, csn8);
      end
      @(negedge CLK);
    end
    rsp_rdy8 = 1'b1;
    @(negedge CLK);
    checks++; if (rsp_ena8 !== 1'b0 || rdy8 !== 1'b1) begin failures++; $display("FAIL bp_accept: ena %b rdy %b want 0 1", rsp_ena8, rdy8); end
  endtask

  task automatic test_back_to_back;
    int n;
    bit bad;
    lb8 = 1'b1;
    issue8(8'h11, 2'd2, 1'b0, 1'b0);
    checks++; if (csn8 !== 4'b1011) begin failures++; $display("FAIL cs2_select: got %b want 1011", csn8); end
    wait_rsp8(4'b1011, n, bad);
    checks++; if (bad || rsp_data8 !== 8'h11) begin failures++; $display("FAIL cs2_xfer: cs_bad %b data %h want 0 11", bad, rsp_data8); end
    @(negedge CLK);
    issue8(8'h96, 2'd3, 1'b0, 1'b0);
    checks++; if (csn8 !== 4'b0111) begin failures++; $display("FAIL cs3_select: got %b want 0111", csn8); end
    wait_rsp8(4'b0111, n, bad);
    checks++; if (bad || n !== 35 || rsp_data8 !== 8'h96) begin failures++; $display("FAIL cs3_xfer: cs_bad %b n %0d data %h want 0 35 96", bad, n, rsp_data8); end
    @(negedge CLK);
    checks++; if (rdy8 !== 1'b1) begin failures++; $display("FAIL b2b_rdy: got %b want 1", rdy8); end
    issue8(8'h69, 2'd1, 1'b0, 1'b0);
    checks++; if (csn8 !== 4'b1101) begin failures++; $display("FAIL cs1_select: got %b want 1101", csn8); end
    wait_rsp8(4'b1101, n, bad);
    checks++; if (bad || n !== 35 || rsp_data8 !== 8'h69) begin failures++; $display("FAIL cs1_xfer: cs_bad %b n %0d data %h want 0 35 69", bad, n, rsp_data8); end
    @(negedge CLK);
  endtask

  task automatic test_div1_width1;
    // data=1, miso=0, cs=0
    data1 = 1'b1; cs1 = 1'b0; cpol1 = 1'b0; cpha1 = 1'b0; miso1 = 1'b0; ena1 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ena1 = 1'b0;
    checks++; if (mosi1 !== 1'b1) begin failures++; $display("FAIL w1_mosi: got %b want 1", mosi1); end
    for (int n = 1; n <= 4; n++) begin
      int e;
      e = (n - 1 > 2) ? 2 : n - 1;
      checks++; if (sclk1 !== e[0]) begin failures++; $display("FAIL w1_sclk n=%0d: got %b want %b", n, sclk1, e[0]); end
      checks++; if (csn1 !== ((n <= 3) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL w1_csn n=%0d: got %b", n, csn1); end
      checks++; if (rsp_ena1 !== (n == 4)) begin failures++; $display("FAIL w1_ena n=%0d: got %b", n, rsp_ena1); end
      if (n < 4) @(negedge CLK);
    end
    checks++; if (rsp_data1 !== 1'b0) begin failures++; $display("FAIL w1_data: got %b want 0", rsp_data1); end
    @(negedge CLK);
    checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL w1_rdy: got %b want 1", rdy1); end
    // Out-of-range chip select: runs unselected, still responds.
    data1 = 1'b0; cs1 = 1'b1; miso1 = 1'b1; ena1 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ena1 = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      checks++; if (csn1 !== 1'b1 || rsp_ena1 !== (n == 4)) begin failures++; $display("FAIL w1_nocs n=%0d: csn %b ena %b", n, csn1, rsp_ena1); end
      if (n < 4) @(negedge CLK);
    end
    checks++; if (rsp_data1 !== 1'b1) begin failures++; $display("FAIL w1_nocs_data: got %b want 1", rsp_data1); end
    @(negedge CLK);
  endtask

  task automatic test_width26;
    int n;
    data26 = 26'h2D5A5C3; cs26 = 1'b0; cpol26 = 1'b0; cpha26 = 1'b1; ena26 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ena26 = 1'b0;
    n = 1;
    while (rsp_ena26 !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    checks++; if (n !== 213) begin failures++; $display("FAIL w26_latency: got n=%0d want 213", n); end
    checks++; if (rsp_data26 !== 26'h2D5A5C3) begin failures++; $display("FAIL w26_data: got %h want 2d5a5c3", rsp_data26); end
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b1;
    ena8 = 1'b0; data8 = 8'h00; cs8 = 2'd0; cpol8 = 1'b0; cpha8 = 1'b0; rsp_rdy8 = 1'b1;
    lb8 = 1'b1; slv_miso = 1'b0; slv_word = 8'h00; slv_cpha = 1'b0; slv_sh = 8'h00; slv_rx = 8'h00; slv_edges = 0;
    ena1 = 1'b0; data1 = 1'b0; cs1 = 1'b0; cpol1 = 1'b0; cpha1 = 1'b0; rsp_rdy1 = 1'b1; miso1 = 1'b0;
    ena26 = 1'b0; data26 = '0; cs26 = 1'b0; cpol26 = 1'b0; cpha26 = 1'b0; rsp_rdy26 = 1'b1;
    @(negedge CLK);
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_div1_width1();
    test_width26();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
